// File: rtl/dump_ctrl.sv
// rtl/dump_ctrl.sv - trace RAM dump sequencer feeding the UART response path (optional abort: DUMP_ABORT_EN)
module dump_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dump_start,
    input  logic [1:0] dump_ch,
    input  logic [8:0] trace_end,
`ifdef DUMP_ABORT_EN
    input  logic       dump_abort,
`endif
    output logic       en,
    output logic [8:0] addr,
    input  logic [7:0] ch1_rdata,
    input  logic [7:0] ch2_rdata,
    input  logic [7:0] ch3_rdata,
    output logic [7:0] resp_data,
    output logic       send_resp,
    input  logic       resp_sent,
    output logic       dump_busy,
    output logic       dump_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [9:0] LAST_BYTE = 10'd511;

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [8:0] rd_addr_q, rd_addr_d;
    logic [9:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] resp_data_q, resp_data_d;
    logic [7:0] sel_rdata;

    // Pick the RAM data of the channel latched at dump acceptance
    always_comb begin
        sel_rdata = ch3_rdata;
        case (ch_q)
            2'b00:   sel_rdata = ch1_rdata;
            2'b01:   sel_rdata = ch2_rdata;
            default: sel_rdata = ch3_rdata;
        endcase
    end

    // Next-state and datapath updates; outputs are decoded from state below
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        rd_addr_d   = rd_addr_q;
        byte_cnt_d  = byte_cnt_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    if (dump_ch == 2'b11) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d       = dump_ch;
                        rd_addr_d  = trace_end + 9'd1;
                        byte_cnt_d = 10'd0;
                        state_d    = S_RD;
                    end
                end
            end
            S_RD:    state_d = S_LATCH;
            S_LATCH: begin
                resp_data_d = sel_rdata;
                state_d     = S_SEND;
            end
            S_SEND:  state_d = S_WAIT;
            S_WAIT: begin
                if (resp_sent) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                        rd_addr_d  = rd_addr_q + 9'd1;
                        state_d    = S_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef DUMP_ABORT_EN
        if (dump_abort && (state_q == S_RD || state_q == S_LATCH ||
                           state_q == S_SEND || state_q == S_WAIT)) begin
            state_d = S_DONE;
        end
`endif
    end

    // State and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= 2'b00;
            rd_addr_q   <= 9'd0;
            byte_cnt_q  <= 10'd0;
            resp_data_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            rd_addr_q   <= rd_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Strobes decode straight from state so reset clears them without a clock
    always_comb begin
        en        = (state_q == S_RD);
        addr      = (state_q == S_RD) ? rd_addr_q : 9'd0;
        send_resp = (state_q == S_SEND);
        dump_busy = (state_q != S_IDLE);
        dump_done = (state_q == S_DONE);
        resp_data = resp_data_q;
    end

endmodule
